// File: rtl/param_seq_alu_pkg.sv
// Shared opcode constants and controller state encoding for the sequential ALU.
package param_seq_alu_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    localparam logic [2:0] OP_OR   = 3'b000;
    localparam logic [2:0] OP_NAND = 3'b001;
    localparam logic [2:0] OP_NOR  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_ACC  = 3'b111;

endpackage

// File: rtl/param_seq_alu_mul.sv
// Iterative shift-add multiplier: bit 0 of B is consumed at start, one more bit per busy cycle.
module param_seq_alu_mul #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] product
);
    localparam int CW = $clog2(W) + 1;

    logic [2*W-1:0] mcand_r;
    logic [2*W-1:0] partial_r;
    logic [W-1:0]   mplier_r;
    logic [CW-1:0]  count_r;
    logic           busy_r;

    // The final iteration is folded into the output so the result is ready as done rises.
    always_comb begin
        product = partial_r + (mplier_r[0] ? mcand_r : {(2*W){1'b0}});
        done    = busy_r && (count_r == CW'(W - 1));
    end

    // Shift registers, partial sum and iteration count.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r    <= 1'b0;
            mcand_r   <= {(2*W){1'b0}};
            partial_r <= {(2*W){1'b0}};
            mplier_r  <= {W{1'b0}};
            count_r   <= {CW{1'b0}};
        end else if (start) begin
            busy_r    <= 1'b1;
            partial_r <= b[0] ? {{W{1'b0}}, a} : {(2*W){1'b0}};
            mcand_r   <= {{(W-1){1'b0}}, a, 1'b0};
            mplier_r  <= b >> 1;
            count_r   <= CW'(1);
        end else if (busy_r) begin
            busy_r    <= !done;
            partial_r <= product;
            mcand_r   <= mcand_r << 1;
            mplier_r  <= mplier_r >> 1;
            count_r   <= count_r + CW'(1);
        end else begin
            busy_r    <= 1'b0;
        end
    end

endmodule

// File: rtl/param_seq_alu.sv
// Sequential ALU: single-cycle logic/arith/accumulate ops plus a W-cycle shift-add multiply.
module param_seq_alu
    import param_seq_alu_pkg::*;
#(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_valid,
    input  logic [2:0]     i_op,
    input  logic [2*W-1:0] i_data,
    output logic           o_ready,
    output logic           o_valid,
    output logic [2*W-1:0] o_result,
    output logic           o_carry,
    output logic           o_zero
);
    state_t         state_r;
    logic           ready_r;
    logic           valid_r;
    logic [2*W-1:0] result_r;
    logic           carry_r;
    logic           zero_r;
    logic [2*W-1:0] acc_r;

    logic [W-1:0]   a_s;
    logic [W-1:0]   b_s;
    logic           accept_s;
    logic [2*W-1:0] alu_res_s;
    logic           alu_carry_s;
    logic [2*W-1:0] acc_next_s;
    logic [2*W:0]   wide_s;
    logic           mul_done_s;
    logic [2*W-1:0] mul_product_s;

    assign a_s      = i_data[2*W-1:W];
    assign b_s      = i_data[W-1:0];
    assign accept_s = i_valid && ready_r;

    assign o_ready  = ready_r;
    assign o_valid  = valid_r;
    assign o_result = result_r;
    assign o_carry  = carry_r;
    assign o_zero   = zero_r;

    // Single-cycle result for every opcode except MUL; acc only moves on ACC.
    always_comb begin
        alu_res_s   = {(2*W){1'b0}};
        alu_carry_s = 1'b0;
        acc_next_s  = acc_r;
        wide_s      = {(2*W+1){1'b0}};
        case (i_op)
            OP_OR:   alu_res_s = {{W{1'b0}}, a_s | b_s};
            OP_NAND: alu_res_s = {{W{1'b0}}, ~(a_s & b_s)};
            OP_NOR:  alu_res_s = {{W{1'b0}}, ~(a_s | b_s)};
            OP_AND:  alu_res_s = {{W{1'b0}}, a_s & b_s};
            OP_ADD: begin
                wide_s      = (2*W+1)'(a_s) + (2*W+1)'(b_s);
                alu_res_s   = wide_s[2*W-1:0];
                alu_carry_s = wide_s[W];
            end
            OP_SUB: begin
                alu_res_s   = {{W{1'b0}}, b_s} - {{W{1'b0}}, a_s};
                alu_carry_s = (b_s < a_s);
            end
            OP_ACC: begin
                wide_s      = {1'b0, acc_r} + (2*W+1)'(a_s) + (2*W+1)'(b_s);
                acc_next_s  = wide_s[2*W-1:0];
                alu_res_s   = wide_s[2*W-1:0];
                alu_carry_s = wide_s[2*W];
            end
            default: alu_res_s = {(2*W){1'b0}};
        endcase
    end

    param_seq_alu_mul #(.W(W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept_s && (i_op == OP_MUL)),
        .a       (a_s),
        .b       (b_s),
        .done    (mul_done_s),
        .product (mul_product_s)
    );

    // Controller FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            ready_r  <= 1'b1;
            valid_r  <= 1'b0;
            result_r <= {(2*W){1'b0}};
            carry_r  <= 1'b0;
            zero_r   <= 1'b1;
            acc_r    <= {(2*W){1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && (i_op == OP_MUL)) begin
                        state_r <= ST_MUL;
                        ready_r <= 1'b0;
                        valid_r <= 1'b0;
                    end else if (accept_s) begin
                        valid_r  <= 1'b1;
                        result_r <= alu_res_s;
                        carry_r  <= alu_carry_s;
                        zero_r   <= (alu_res_s == {(2*W){1'b0}});
                        acc_r    <= acc_next_s;
                    end else begin
                        valid_r  <= 1'b0;
                    end
                end
                ST_MUL: begin
                    if (mul_done_s) begin
                        state_r  <= ST_IDLE;
                        ready_r  <= 1'b1;
                        valid_r  <= 1'b1;
                        result_r <= mul_product_s;
                        carry_r  <= 1'b0;
                        zero_r   <= (mul_product_s == {(2*W){1'b0}});
                    end else begin
                        valid_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
